// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: program counter owner and IF/ID holding register.
// Drives the fetcher address and hands captured words to decode.
package defs;
  localparam int MEM_SIZE = 256;
endpackage

module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = defs::MEM_SIZE,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_addr,
  input  logic [31:0] fetch_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic        vld_nx;
  logic        pc_ok;
  logic        consume;
  logic        fire;
  logic        fault_set;

  assign fetch_addr = pc;
  assign pc_ok = (pc < 32'(MEM_SIZE))
               && (pc[1:0] == 2'b00);
  assign consume = out_valid && out_ready;
  assign fire = (state == RUN)
              && !redirect_valid
              && pc_ok
              && (!out_valid || out_ready);
  assign fault_set = (state == RUN)
                   && !redirect_valid
                   && !pc_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE) || redirect_valid:
        state_nx = RUN;
      fault_set:
        state_nx = HALT;
      default:
        state_nx = state;
    endcase
  end

  // Redirect drops the held word even if decode is ready this cycle.
  always_comb begin
    pc_nx  = pc;
    vld_nx = out_valid;
    if (redirect_valid) begin
      pc_nx  = redirect_pc;
      vld_nx = 1'b0;
    end else if (fire) begin
      pc_nx  = pc + PC_STEP;
      vld_nx = 1'b1;
    end else if (consume) begin
      vld_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_inst    <= 32'd0;
      out_pc      <= 32'd0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc        <= pc_nx;
      out_valid <= vld_nx;
      if (fire) begin
        out_inst    <= fetch_inst;
        out_pc      <= pc;
        fetch_count <= fetch_count + 32'd1;
      end
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule
